// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C EEPROM sequencer: engine commands, bus r/w bit,
// and the state enums of the sequencer and its byte issuer.
package i2c_pkg;

   // eng_cmd: bit0 go, bit1 write(1)/read(0), bit2 stop after this byte
   localparam logic [2:0] CMD_NOP     = 3'b000;
   localparam logic [2:0] CMD_RD      = 3'b001;
   localparam logic [2:0] CMD_WR      = 3'b011;
   localparam logic [2:0] CMD_RD_STOP = 3'b101;
   localparam logic [2:0] CMD_WR_STOP = 3'b111;

   // Value of the r/w bit in the I2C control byte
   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ  = 1'b1;

   typedef enum logic [3:0] {
      SEQ_IDLE,
      SEQ_CHECK,
      SEQ_CTRL_W,
      SEQ_ADDR_HI,
      SEQ_ADDR_LO,
      SEQ_WDATA,
      SEQ_POLL,
      SEQ_CTRL_R,
      SEQ_RDATA,
      SEQ_DONE
   } seq_state_t;

   typedef enum logic [1:0] {
      ISS_IDLE,
      ISS_ISSUE,
      ISS_WAIT_HI,
      ISS_WAIT_LO
   } iss_state_t;

   function automatic logic [7:0] ctrl_byte(input logic [6:0] dev, input logic rw);
      return {dev, rw};
   endfunction

endpackage

// File: rtl/i2c_byte_issuer.sv
// Runs one engine byte transaction: a single-cycle go, then waits for busy to
// rise and fall; done/error/din are valid combinationally in the completing cycle.
module i2c_byte_issuer
   import i2c_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_start,
   input  logic [2:0] i_cmd,
   input  logic [7:0] i_dout,
   output logic       o_idle,
   output logic       o_done,
   output logic       o_error,
   output logic [7:0] o_din,
   output logic [2:0] o_eng_cmd,
   output logic [7:0] o_eng_dout,
   input  logic       i_eng_busy,
   input  logic       i_eng_error,
   input  logic [7:0] i_eng_din,
   output iss_state_t o_state
);

   iss_state_t r_state;
   iss_state_t w_next;
   logic [2:0] r_cmd;
   logic [7:0] r_dout;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ISS_IDLE;
         r_cmd   <= CMD_NOP;
         r_dout  <= '0;
      end else begin
         r_state <= w_next;
         // Command and byte are captured once so eng_dout stays put until completion
         if (r_state == ISS_IDLE && i_start) begin
            r_cmd  <= i_cmd;
            r_dout <= i_dout;
         end
      end
   end

   always_comb begin
      w_next    = r_state;
      o_done    = 1'b0;
      o_eng_cmd = CMD_NOP;
      case (r_state)
         ISS_IDLE: begin
            if (i_start) w_next = ISS_ISSUE;
         end
         ISS_ISSUE: begin
            o_eng_cmd = r_cmd;
            w_next    = ISS_WAIT_HI;
         end
         ISS_WAIT_HI: begin
            if (i_eng_busy) w_next = ISS_WAIT_LO;
         end
         ISS_WAIT_LO: begin
            if (!i_eng_busy) begin
               o_done = 1'b1;
               w_next = ISS_IDLE;
            end
         end
         default: w_next = ISS_IDLE;
      endcase
   end

   assign o_idle     = (r_state == ISS_IDLE);
   assign o_error    = i_eng_error;
   assign o_din      = i_eng_din;
   assign o_eng_dout = r_dout;
   assign o_state    = r_state;

endmodule

// File: rtl/i2c_eeprom_seq.sv
// EEPROM transaction sequencer: expands one burst read/write request into the
// byte command stream for the i2c engine, with page check and post-write polling.
module i2c_eeprom_seq
   import i2c_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR   = 7'h50,
   parameter int         ADDR_BYTES = 2,
   parameter int         MAX_BURST  = 16,
   parameter int         PAGE_BYTES = 16,
   parameter int         POLL_LIMIT = 255,
   localparam int        LEN_W      = $clog2(MAX_BURST)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_write,
   input  logic [15:0]      req_addr,
   input  logic [LEN_W-1:0] req_len,
   input  logic [7:0]       wr_data,
   input  logic             wr_valid,
   output logic             wr_ready,
   output logic [7:0]       rd_data,
   output logic             rd_valid,
   output logic             done,
   output logic             err,
   output logic [2:0]       eng_cmd,
   output logic [7:0]       eng_dout,
   input  logic [7:0]       eng_din,
   input  logic             eng_busy,
   input  logic             eng_error,
   output logic [5:0]       o_dbg_state
);

   localparam int PG_W   = $clog2(PAGE_BYTES);
   localparam int SUM_W  = LEN_W + 2;
   localparam int POLL_W = $clog2(POLL_LIMIT + 1);

   // Handshake: a request transfers on a cycle with req_valid && req_ready;
   // a write byte transfers on a cycle with wr_valid && wr_ready.

   seq_state_t       r_state;
   seq_state_t       w_next;
   logic             r_write;
   logic [15:0]      r_addr;
   logic [LEN_W-1:0] r_cnt;
   logic [POLL_W-1:0] r_poll;
   logic             r_err;
   logic [7:0]       r_rd_data;
   logic             r_rd_valid;

   logic             w_accept;
   logic             w_start;
   logic [2:0]       w_cmd;
   logic [7:0]       w_dout;
   logic             w_err_set;
   logic             w_err_val;
   logic             w_cnt_dec;
   logic             w_poll_inc;
   logic             w_rd_cap;
   logic             w_wr_ready;
   logic             w_last;
   logic [SUM_W-1:0] w_page_sum;
   logic             w_page_bad;
   logic             w_iss_idle;
   logic             w_iss_done;
   logic             w_iss_err;
   logic [7:0]       w_iss_din;
   iss_state_t       w_iss_state;

   assign w_accept   = (r_state == SEQ_IDLE) && req_valid;
   assign w_last     = (r_cnt == '0);
   assign w_page_sum = SUM_W'(r_addr[PG_W-1:0]) + SUM_W'(r_cnt) + SUM_W'(1);
   assign w_page_bad = (w_page_sum > SUM_W'(PAGE_BYTES));

   i2c_byte_issuer u_issuer (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_start     (w_start),
      .i_cmd       (w_cmd),
      .i_dout      (w_dout),
      .o_idle      (w_iss_idle),
      .o_done      (w_iss_done),
      .o_error     (w_iss_err),
      .o_din       (w_iss_din),
      .o_eng_cmd   (eng_cmd),
      .o_eng_dout  (eng_dout),
      .i_eng_busy  (eng_busy),
      .i_eng_error (eng_error),
      .i_eng_din   (eng_din),
      .o_state     (w_iss_state)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= SEQ_IDLE;
         r_write    <= 1'b0;
         r_addr     <= '0;
         r_cnt      <= '0;
         r_poll     <= '0;
         r_err      <= 1'b0;
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_rd_valid <= w_rd_cap;
         if (w_accept) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_cnt   <= req_len;
            r_poll  <= '0;
         end else if (w_cnt_dec) begin
            r_cnt <= r_cnt - 1'b1;
         end
         if (w_poll_inc) r_poll <= r_poll + 1'b1;
         if (w_err_set)  r_err <= w_err_val;
         if (w_rd_cap)   r_rd_data <= w_iss_din;
      end
   end

   // A byte state starts the issuer whenever it is idle; on completion the
   // state either advances or repeats, and the next byte starts a cycle later.
   always_comb begin
      w_next     = r_state;
      w_start    = 1'b0;
      w_cmd      = CMD_NOP;
      w_dout     = '0;
      w_err_set  = 1'b0;
      w_err_val  = 1'b0;
      w_cnt_dec  = 1'b0;
      w_poll_inc = 1'b0;
      w_rd_cap   = 1'b0;
      w_wr_ready = 1'b0;
      case (r_state)
         SEQ_IDLE: begin
            if (req_valid) w_next = SEQ_CHECK;
         end
         SEQ_CHECK: begin
            if (r_write && w_page_bad) begin
               w_next    = SEQ_DONE;
               w_err_set = 1'b1;
               w_err_val = 1'b1;
            end else begin
               w_next = SEQ_CTRL_W;
            end
         end
         SEQ_CTRL_W: begin
            w_cmd   = CMD_WR;
            w_dout  = ctrl_byte(DEV_ADDR, RW_WRITE);
            w_start = w_iss_idle;
            if (w_iss_done) w_next = (ADDR_BYTES == 2) ? SEQ_ADDR_HI : SEQ_ADDR_LO;
         end
         SEQ_ADDR_HI: begin
            w_cmd   = CMD_WR;
            w_dout  = r_addr[15:8];
            w_start = w_iss_idle;
            if (w_iss_done) w_next = SEQ_ADDR_LO;
         end
         SEQ_ADDR_LO: begin
            // A read only sets the address pointer, then restarts for the read phase
            w_cmd   = r_write ? CMD_WR : CMD_WR_STOP;
            w_dout  = r_addr[7:0];
            w_start = w_iss_idle;
            if (w_iss_done) w_next = r_write ? SEQ_WDATA : SEQ_CTRL_R;
         end
         SEQ_WDATA: begin
            w_cmd      = w_last ? CMD_WR_STOP : CMD_WR;
            w_dout     = wr_data;
            w_start    = w_iss_idle && wr_valid;
            w_wr_ready = w_iss_idle && wr_valid;
            if (w_iss_done) begin
               if (w_last) w_next = SEQ_POLL;
               else        w_cnt_dec = 1'b1;
            end
         end
         SEQ_POLL: begin
            w_cmd   = CMD_WR_STOP;
            w_dout  = ctrl_byte(DEV_ADDR, RW_WRITE);
            w_start = w_iss_idle;
            if (w_iss_done) begin
               if (!w_iss_err) begin
                  w_next    = SEQ_DONE;
                  w_err_set = 1'b1;
               end else if (r_poll == POLL_W'(POLL_LIMIT - 1)) begin
                  w_next    = SEQ_DONE;
                  w_err_set = 1'b1;
                  w_err_val = 1'b1;
               end else begin
                  w_poll_inc = 1'b1;
               end
            end
         end
         SEQ_CTRL_R: begin
            w_cmd   = CMD_WR;
            w_dout  = ctrl_byte(DEV_ADDR, RW_READ);
            w_start = w_iss_idle;
            if (w_iss_done) w_next = SEQ_RDATA;
         end
         SEQ_RDATA: begin
            w_cmd   = w_last ? CMD_RD_STOP : CMD_RD;
            w_start = w_iss_idle;
            if (w_iss_done) begin
               w_rd_cap = 1'b1;
               if (w_last) begin
                  w_next    = SEQ_DONE;
                  w_err_set = 1'b1;
               end else begin
                  w_cnt_dec = 1'b1;
               end
            end
         end
         SEQ_DONE: begin
            w_next = SEQ_IDLE;
         end
         default: w_next = SEQ_IDLE;
      endcase

      // A NACK outside polling ends the request; the engine has already stopped
      if (w_iss_done && w_iss_err && r_state != SEQ_POLL) begin
         w_next    = SEQ_DONE;
         w_err_set = 1'b1;
         w_err_val = 1'b1;
         w_cnt_dec = 1'b0;
         w_rd_cap  = 1'b0;
      end
   end

   assign req_ready   = (r_state == SEQ_IDLE);
   assign wr_ready    = w_wr_ready;
   assign rd_data     = r_rd_data;
   assign rd_valid    = r_rd_valid;
   assign done        = (r_state == SEQ_DONE);
   assign err         = (r_state == SEQ_DONE) && r_err;
   assign o_dbg_state = {w_iss_state, r_state};

endmodule

// File: tb/tb_i2c_eeprom_seq.sv
// Directed bench for i2c_eeprom_seq: two instances (2-byte and 1-byte addressing)
// share one behavioural i2c engine model selected by sel.
module tb_i2c_eeprom_seq;
   import i2c_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        sel;
   logic        req_valid;
   logic        req_write;
   logic [15:0] req_addr;
   logic [3:0]  req_len;
   logic        wr_valid;
   logic [7:0]  wr_data;

   logic        req_ready_a, wr_ready_a, rd_valid_a, done_a, err_a;
   logic [7:0]  rd_data_a, eng_dout_a;
   logic [2:0]  eng_cmd_a;
   logic [5:0]  dbg_a;
   logic        req_ready_b, wr_ready_b, rd_valid_b, done_b, err_b;
   logic [7:0]  rd_data_b, eng_dout_b;
   logic [2:0]  eng_cmd_b;
   logic [5:0]  dbg_b;

   logic        m_busy, m_err;
   logic [7:0]  m_din;

   int checks = 0;
   int errors = 0;

   i2c_eeprom_seq #(.ADDR_BYTES(2), .POLL_LIMIT(4)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid & ~sel), .req_ready(req_ready_a),
      .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
      .wr_data(wr_data), .wr_valid(wr_valid & ~sel), .wr_ready(wr_ready_a),
      .rd_data(rd_data_a), .rd_valid(rd_valid_a), .done(done_a), .err(err_a),
      .eng_cmd(eng_cmd_a), .eng_dout(eng_dout_a), .eng_din(m_din),
      .eng_busy(m_busy & ~sel), .eng_error(m_err & ~sel), .o_dbg_state(dbg_a)
   );

   i2c_eeprom_seq #(.ADDR_BYTES(1)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid & sel), .req_ready(req_ready_b),
      .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
      .wr_data(wr_data), .wr_valid(wr_valid & sel), .wr_ready(wr_ready_b),
      .rd_data(rd_data_b), .rd_valid(rd_valid_b), .done(done_b), .err(err_b),
      .eng_cmd(eng_cmd_b), .eng_dout(eng_dout_b), .eng_din(m_din),
      .eng_busy(m_busy & sel), .eng_error(m_err & sel), .o_dbg_state(dbg_b)
   );

   logic [2:0] s_cmd;
   logic [7:0] s_dout, s_rd_data;
   logic       s_req_ready, s_wr_ready, s_rd_valid, s_done, s_err;
   logic [5:0] s_dbg;
   assign s_cmd       = sel ? eng_cmd_b   : eng_cmd_a;
   assign s_dout      = sel ? eng_dout_b  : eng_dout_a;
   assign s_rd_data   = sel ? rd_data_b   : rd_data_a;
   assign s_req_ready = sel ? req_ready_b : req_ready_a;
   assign s_wr_ready  = sel ? wr_ready_b  : wr_ready_a;
   assign s_rd_valid  = sel ? rd_valid_b  : rd_valid_a;
   assign s_done      = sel ? done_b      : done_a;
   assign s_err       = sel ? err_b       : err_a;
   assign s_dbg       = sel ? dbg_b       : dbg_a;

   // ---------------- engine model ----------------
   int          go_cnt = 0, poll_cnt = 0, rd_cnt = 0;
   int          nack_at = -1, poll_ref = 0, poll_nack_n = 0, rd_ref = 0;
   logic [7:0]  rd_mem [16];
   logic [10:0] log_q [$];
   logic        p_err;
   logic [7:0]  p_din;
   int          m_left;
   logic [3:0]  rd_ix;
   assign rd_ix = 4'(rd_cnt - rd_ref);

   always @(posedge clk) begin
      if (!rst_n) begin
         m_busy <= 1'b0;
         m_err  <= 1'b0;
         m_din  <= 8'h00;
         m_left <= 0;
      end else if (s_cmd[0]) begin
         log_q.push_back({s_cmd, s_dout});
         go_cnt <= go_cnt + 1;
         m_busy <= 1'b1;
         m_left <= 2;
         p_err  <= (go_cnt == nack_at);
         p_din  <= 8'h00;
         if (s_cmd == CMD_WR_STOP && s_dout == 8'hA0) begin
            poll_cnt <= poll_cnt + 1;
            p_err    <= (go_cnt == nack_at) || ((poll_cnt - poll_ref) < poll_nack_n);
         end
         if (!s_cmd[1]) begin
            rd_cnt <= rd_cnt + 1;
            p_din  <= rd_mem[rd_ix];
         end
      end else if (m_busy) begin
         if (m_left == 0) begin
            m_busy <= 1'b0;
            m_err  <= p_err;
            m_din  <= p_din;
         end else begin
            m_left <= m_left - 1;
         end
      end
   end

   // ---------------- write-data source ----------------
   int         wr_idx = 0, wr_ref = 0, wr_n = 0, wr_pulses = 0;
   logic [7:0] wr_buf [16];
   logic [3:0] wr_ix;
   assign wr_ix    = 4'(wr_idx - wr_ref);
   assign wr_valid = (wr_idx - wr_ref) < wr_n;
   assign wr_data  = wr_buf[wr_ix];

   always @(posedge clk) begin
      if (rst_n && s_wr_ready) begin
         wr_idx    <= wr_idx + 1;
         wr_pulses <= wr_pulses + 1;
      end
   end

   // ---------------- output monitor ----------------
   int         done_cnt = 0, rdv_cnt = 0;
   logic [7:0] rd_seen [$];
   always @(negedge clk) begin
      if (s_done)     done_cnt <= done_cnt + 1;
      if (s_rd_valid) begin
         rdv_cnt <= rdv_cnt + 1;
         rd_seen.push_back(s_rd_data);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_req(input logic w, input logic [15:0] a, input logic [3:0] l);
      @(negedge clk);
      req_write = w;
      req_addr  = a;
      req_len   = l;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic wait_done(output bit ok, output logic e);
      ok = 1'b0;
      e  = 1'b0;
      for (int i = 0; i < 600 && !ok; i++) begin
         @(negedge clk);
         if (s_done) begin
            ok = 1'b1;
            e  = s_err;
         end
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      idle_cycles(3);
      checks++; if (s_req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %0b expected 1", s_req_ready); end
      checks++; if (s_cmd !== 3'b000) begin errors++; $display("FAIL reset_eng_cmd: got %0h expected 0", s_cmd); end
      checks++; if (s_dout !== 8'h00) begin errors++; $display("FAIL reset_eng_dout: got %0h expected 0", s_dout); end
      checks++; if ({s_wr_ready, s_rd_valid, s_done, s_err} !== 4'b0000) begin errors++; $display("FAIL reset_strobes: got %0b expected 0000", {s_wr_ready, s_rd_valid, s_done, s_err}); end
      checks++; if (s_rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %0h expected 0", s_rd_data); end
      checks++; if (s_dbg !== 6'h00) begin errors++; $display("FAIL reset_state: got %0h expected 0", s_dbg); end
      rst_n = 1'b1;
      idle_cycles(2);
   endtask

   task automatic test_write_burst();
      logic [10:0] exp_q[$];
      int lb, gb, wb, db;
      bit ok;
      logic e;
      exp_q = '{11'h3A0, 11'h300, 11'h310, 11'h3A5, 11'h35A, 11'h3C3, 11'h73C,
                11'h7A0, 11'h7A0, 11'h7A0};
      sel = 1'b0;
      poll_ref = poll_cnt; poll_nack_n = 2; nack_at = -1;
      wr_buf[0] = 8'hA5; wr_buf[1] = 8'h5A; wr_buf[2] = 8'hC3; wr_buf[3] = 8'h3C;
      wr_ref = wr_idx; wr_n = 4;
      lb = log_q.size(); gb = go_cnt; wb = wr_pulses; db = done_cnt;
      send_req(1'b1, 16'h0010, 4'd3);
      checks++; if (s_req_ready !== 1'b0) begin errors++; $display("FAIL wr_ready_drop: got %0b expected 0", s_req_ready); end
      wait_done(ok, e);
      checks++; if (!ok) begin errors++; $display("FAIL wr_done_timeout: got no done expected done"); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL wr_err: got %0b expected 0", e); end
      idle_cycles(3);
      checks++; if (log_q.size() - lb != 10) begin errors++; $display("FAIL wr_byte_count: got %0d expected 10", log_q.size() - lb); end
      for (int i = 0; i < 10 && lb + i < log_q.size(); i++) begin
         checks++; if (log_q[lb + i] !== exp_q[i]) begin errors++; $display("FAIL wr_byte%0d: got %0h expected %0h", i, log_q[lb + i], exp_q[i]); end
      end
      checks++; if (wr_pulses - wb != 4) begin errors++; $display("FAIL wr_ready_pulses: got %0d expected 4", wr_pulses - wb); end
      checks++; if (done_cnt - db != 1) begin errors++; $display("FAIL wr_done_count: got %0d expected 1", done_cnt - db); end
      checks++; if (s_req_ready !== 1'b1) begin errors++; $display("FAIL wr_back_to_idle: got %0b expected 1", s_req_ready); end
   endtask

   task automatic test_read_1byte_addr();
      logic [10:0] exp_q[$];
      int lb, rb, sb;
      bit ok;
      logic e;
      exp_q = '{11'h3A0, 11'h700, 11'h3A1, 11'h100, 11'h500};
      sel = 1'b1;
      rd_ref = rd_cnt; rd_mem[0] = 8'h11; rd_mem[1] = 8'h22;
      lb = log_q.size(); rb = rdv_cnt; sb = rd_seen.size();
      send_req(1'b0, 16'h0000, 4'd1);
      wait_done(ok, e);
      checks++; if (!ok) begin errors++; $display("FAIL rd_done_timeout: got no done expected done"); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL rd_err: got %0b expected 0", e); end
      idle_cycles(3);
      checks++; if (log_q.size() - lb != 5) begin errors++; $display("FAIL rd_byte_count: got %0d expected 5", log_q.size() - lb); end
      for (int i = 0; i < 5 && lb + i < log_q.size(); i++) begin
         if (exp_q[i][9]) begin
            checks++; if (log_q[lb + i] !== exp_q[i]) begin errors++; $display("FAIL rd_byte%0d: got %0h expected %0h", i, log_q[lb + i], exp_q[i]); end
         end else begin
            checks++; if (log_q[lb + i][10:8] !== exp_q[i][10:8]) begin errors++; $display("FAIL rd_cmd%0d: got %0h expected %0h", i, log_q[lb + i][10:8], exp_q[i][10:8]); end
         end
      end
      checks++; if (rdv_cnt - rb != 2) begin errors++; $display("FAIL rd_valid_count: got %0d expected 2", rdv_cnt - rb); end
      if (rd_seen.size() >= sb + 2) begin
         checks++; if (rd_seen[sb] !== 8'h11) begin errors++; $display("FAIL rd_data0: got %0h expected 11", rd_seen[sb]); end
         checks++; if (rd_seen[sb + 1] !== 8'h22) begin errors++; $display("FAIL rd_data1: got %0h expected 22", rd_seen[sb + 1]); end
      end
      sel = 1'b0;
   endtask

   task automatic test_page_violation();
      int gb;
      sel = 1'b0;
      gb = go_cnt;
      send_req(1'b1, 16'h000E, 4'd3);
      @(negedge clk);
      checks++; if (s_done !== 1'b0) begin errors++; $display("FAIL page_done_early: got %0b expected 0", s_done); end
      @(negedge clk);
      checks++; if (s_done !== 1'b1) begin errors++; $display("FAIL page_done_cycle2: got %0b expected 1", s_done); end
      checks++; if (s_err !== 1'b1) begin errors++; $display("FAIL page_err: got %0b expected 1", s_err); end
      idle_cycles(5);
      checks++; if (go_cnt - gb != 0) begin errors++; $display("FAIL page_no_traffic: got %0d go pulses expected 0", go_cnt - gb); end
   endtask

   task automatic test_nack_ctrl();
      int lb, gb, wb;
      bit ok;
      logic e;
      sel = 1'b0;
      nack_at = go_cnt;
      wr_buf[0] = 8'h77; wr_ref = wr_idx; wr_n = 1;
      lb = log_q.size(); gb = go_cnt; wb = wr_pulses;
      send_req(1'b1, 16'h0020, 4'd0);
      wait_done(ok, e);
      checks++; if (!ok) begin errors++; $display("FAIL nack_done_timeout: got no done expected done"); end
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL nack_err: got %0b expected 1", e); end
      idle_cycles(20);
      checks++; if (go_cnt - gb != 1) begin errors++; $display("FAIL nack_go_count: got %0d expected 1", go_cnt - gb); end
      if (log_q.size() > lb) begin
         checks++; if (log_q[lb] !== 11'h3A0) begin errors++; $display("FAIL nack_byte0: got %0h expected 3a0", log_q[lb]); end
      end
      checks++; if (wr_pulses - wb != 0) begin errors++; $display("FAIL nack_wr_ready: got %0d expected 0", wr_pulses - wb); end
      nack_at = -1;
      wr_n = 0;
   endtask

   task automatic test_poll_timeout();
      logic [10:0] exp_q[$];
      int lb, pb;
      bit ok;
      logic e;
      exp_q = '{11'h3A0, 11'h300, 11'h330, 11'h799, 11'h7A0, 11'h7A0, 11'h7A0, 11'h7A0};
      sel = 1'b0;
      poll_ref = poll_cnt; poll_nack_n = 1000;
      wr_buf[0] = 8'h99; wr_ref = wr_idx; wr_n = 1;
      lb = log_q.size(); pb = poll_cnt;
      send_req(1'b1, 16'h0030, 4'd0);
      wait_done(ok, e);
      checks++; if (!ok) begin errors++; $display("FAIL poll_done_timeout: got no done expected done"); end
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL poll_err: got %0b expected 1", e); end
      idle_cycles(10);
      checks++; if (poll_cnt - pb != 4) begin errors++; $display("FAIL poll_count: got %0d expected 4", poll_cnt - pb); end
      checks++; if (log_q.size() - lb != 8) begin errors++; $display("FAIL poll_byte_count: got %0d expected 8", log_q.size() - lb); end
      for (int i = 0; i < 8 && lb + i < log_q.size(); i++) begin
         checks++; if (log_q[lb + i] !== exp_q[i]) begin errors++; $display("FAIL poll_byte%0d: got %0h expected %0h", i, log_q[lb + i], exp_q[i]); end
      end
      poll_nack_n = 0;
   endtask

   task automatic test_reset_mid_read();
      int gb, db, rb, lb, sb;
      bit hit, ok;
      logic e;
      sel = 1'b0;
      rd_ref = rd_cnt;
      rd_mem[0] = 8'h01; rd_mem[1] = 8'h02; rd_mem[2] = 8'h03; rd_mem[3] = 8'h04;
      gb = go_cnt; rb = rdv_cnt;
      send_req(1'b0, 16'h0040, 4'd3);
      hit = 1'b0;
      for (int i = 0; i < 400 && !hit; i++) begin
         @(negedge clk);
         if (go_cnt - gb >= 6) hit = 1'b1;
      end
      checks++; if (!hit) begin errors++; $display("FAIL rst_reach_byte2: got %0d go pulses expected 6", go_cnt - gb); end
      rst_n = 1'b0;
      db = done_cnt;
      @(negedge clk);
      checks++; if (s_cmd !== 3'b000) begin errors++; $display("FAIL rst_eng_cmd: got %0h expected 0", s_cmd); end
      checks++; if (s_req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %0b expected 1", s_req_ready); end
      rst_n = 1'b1;
      idle_cycles(15);
      checks++; if (done_cnt - db != 0) begin errors++; $display("FAIL rst_no_done: got %0d expected 0", done_cnt - db); end
      checks++; if (rdv_cnt - rb != 1) begin errors++; $display("FAIL rst_rd_valid_count: got %0d expected 1", rdv_cnt - rb); end

      rd_ref = rd_cnt; rd_mem[0] = 8'hAB;
      lb = log_q.size(); sb = rd_seen.size();
      send_req(1'b0, 16'h0050, 4'd0);
      wait_done(ok, e);
      checks++; if (!ok) begin errors++; $display("FAIL rst_next_timeout: got no done expected done"); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL rst_next_err: got %0b expected 0", e); end
      idle_cycles(3);
      checks++; if (log_q.size() - lb != 5) begin errors++; $display("FAIL rst_next_bytes: got %0d expected 5", log_q.size() - lb); end
      if (log_q.size() - lb >= 5) begin
         checks++; if (log_q[lb + 2] !== 11'h750) begin errors++; $display("FAIL rst_next_addr_lo: got %0h expected 750", log_q[lb + 2]); end
         checks++; if (log_q[lb + 4][10:8] !== CMD_RD_STOP) begin errors++; $display("FAIL rst_next_rd_cmd: got %0h expected 5", log_q[lb + 4][10:8]); end
      end
      checks++; if (rd_seen.size() != sb + 1 || rd_seen[rd_seen.size() - 1] !== 8'hAB) begin errors++; $display("FAIL rst_next_rd_data: got %0d bytes last %0h expected 1 byte ab", rd_seen.size() - sb, rd_seen[rd_seen.size() - 1]); end
   endtask

   initial begin
      sel = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
      for (int i = 0; i < 16; i++) begin
         rd_mem[i] = 8'h00;
         wr_buf[i] = 8'h00;
      end
      test_reset();
      test_write_burst();
      test_read_1byte_addr();
      test_page_violation();
      test_nack_ctrl();
      test_poll_timeout();
      test_reset_mid_read();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
